// File: rtl/lsu_issue_queue.sv
// Out-of-order LSU issue queue: age-matrix oldest-eligible select with conservative memory ordering.
// Define LSU_IQ_LOAD_BYPASS_EN to let ready loads pass older not-ready loads; otherwise all ops issue in order.
module lsu_issue_queue #(
    parameter int DEPTH      = 8,
    parameter int ROB_WIDTH  = 4,
    parameter int PREG_WIDTH = 7,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_disp_valid,
    output logic                    o_disp_ready,
    input  logic                    i_disp_memwrite,
    input  logic [3:0]              i_disp_alu_op,
    input  logic [DATA_WIDTH-1:0]   i_disp_offset,
    input  logic [PREG_WIDTH-1:0]   i_disp_prs1,
    input  logic [PREG_WIDTH-1:0]   i_disp_prs2,
    input  logic                    i_disp_prs1_rdy,
    input  logic                    i_disp_prs2_rdy,
    input  logic [PREG_WIDTH-1:0]   i_disp_prd,
    input  logic [ROB_WIDTH-1:0]    i_disp_rob_tag,
    input  logic                    i_wb0_valid,
    input  logic [PREG_WIDTH-1:0]   i_wb0_prd,
    input  logic                    i_wb1_valid,
    input  logic [PREG_WIDTH-1:0]   i_wb1_prd,
    output logic                    o_iss_valid,
    input  logic                    i_lsu_ready,
    output logic                    o_iss_memwrite,
    output logic [3:0]              o_iss_alu_op,
    output logic [DATA_WIDTH-1:0]   o_iss_offset,
    output logic [PREG_WIDTH-1:0]   o_iss_prs1,
    output logic [PREG_WIDTH-1:0]   o_iss_prs2,
    output logic [PREG_WIDTH-1:0]   o_iss_prd,
    output logic [ROB_WIDTH-1:0]    o_iss_rob_tag,
    input  logic                    branch_mispredict,
    input  logic [ROB_WIDTH-1:0]    branch_rob_tag,
    output logic [$clog2(DEPTH):0]  o_count
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DEPTH-1:0]      valid, memwrite, rdy1, rdy2;
    logic [3:0]            alu_op [DEPTH];
    logic [DATA_WIDTH-1:0] offset [DEPTH];
    logic [PREG_WIDTH-1:0] prs1   [DEPTH];
    logic [PREG_WIDTH-1:0] prs2   [DEPTH];
    logic [PREG_WIDTH-1:0] prd    [DEPTH];
    logic [ROB_WIDTH-1:0]  rob    [DEPTH];
    // age[i][j] = 1 means entry j is older than entry i
    logic [DEPTH-1:0]      age    [DEPTH];

    logic [DEPTH-1:0] elig, sel, kill, free_oh;
    logic             disp_keep, issue_fire;

    function automatic logic is_younger(input logic [ROB_WIDTH-1:0] tag,
                                        input logic [ROB_WIDTH-1:0] br);
        logic [ROB_WIDTH-1:0] d;
        d = tag - br;
        return (d != {ROB_WIDTH{1'b0}}) && !d[ROB_WIDTH-1];
    endfunction

    function automatic logic wake(input logic [PREG_WIDTH-1:0] tag);
        return (i_wb0_valid && (i_wb0_prd == tag)) || (i_wb1_valid && (i_wb1_prd == tag));
    endfunction

    // Per-entry eligibility under the memory ordering rules
    always_comb begin
        elig = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (memwrite[i]) begin
                elig[i] = valid[i] & rdy1[i] & rdy2[i] & ~|(age[i] & valid);
            end else begin
`ifdef LSU_IQ_LOAD_BYPASS_EN
                elig[i] = valid[i] & rdy1[i] & ~|(age[i] & valid & memwrite);
`else
                elig[i] = valid[i] & rdy1[i] & ~|(age[i] & valid);
`endif
            end
        end
    end

    // Oldest eligible entry: no older entry is also eligible (one-hot)
    always_comb begin
        sel = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            sel[i] = elig[i] & ~|(age[i] & elig);
        end
    end

    // Issue port mux, occupancy, free slot and kill mask
    always_comb begin
        o_iss_valid    = |elig;
        o_iss_memwrite = 1'b0;
        o_iss_alu_op   = 4'd0;
        o_iss_offset   = {DATA_WIDTH{1'b0}};
        o_iss_prs1     = {PREG_WIDTH{1'b0}};
        o_iss_prs2     = {PREG_WIDTH{1'b0}};
        o_iss_prd      = {PREG_WIDTH{1'b0}};
        o_iss_rob_tag  = {ROB_WIDTH{1'b0}};
        o_count        = {CW{1'b0}};
        free_oh        = {DEPTH{1'b0}};
        kill           = {DEPTH{1'b0}};
        issue_fire     = (|elig) & i_lsu_ready;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel[i]) begin
                o_iss_memwrite = memwrite[i];
                o_iss_alu_op   = alu_op[i];
                o_iss_offset   = offset[i];
                o_iss_prs1     = prs1[i];
                o_iss_prs2     = prs2[i];
                o_iss_prd      = prd[i];
                o_iss_rob_tag  = rob[i];
            end else begin
                o_iss_memwrite = o_iss_memwrite;
            end
            o_count = o_count + CW'(valid[i]);
            if (!valid[i] && (free_oh == {DEPTH{1'b0}})) begin
                free_oh[i] = 1'b1;
            end else begin
                free_oh[i] = 1'b0;
            end
            kill[i] = (issue_fire & sel[i]) |
                      (branch_mispredict & valid[i] & is_younger(rob[i], branch_rob_tag));
        end
        o_disp_ready = (o_count < FULL_CNT);
        disp_keep    = i_disp_valid & o_disp_ready &
                       ~(branch_mispredict & is_younger(i_disp_rob_tag, branch_rob_tag));
    end

    // Entry state: dispatch write, wakeup capture, issue/flush free, age column clear
    always_ff @(posedge clk) begin
        if (reset) begin
            valid    <= {DEPTH{1'b0}};
            memwrite <= {DEPTH{1'b0}};
            rdy1     <= {DEPTH{1'b0}};
            rdy2     <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                alu_op[i] <= 4'd0;
                offset[i] <= {DATA_WIDTH{1'b0}};
                prs1[i]   <= {PREG_WIDTH{1'b0}};
                prs2[i]   <= {PREG_WIDTH{1'b0}};
                prd[i]    <= {PREG_WIDTH{1'b0}};
                rob[i]    <= {ROB_WIDTH{1'b0}};
                age[i]    <= {DEPTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (disp_keep && free_oh[i]) begin
                    valid[i]    <= 1'b1;
                    memwrite[i] <= i_disp_memwrite;
                    alu_op[i]   <= i_disp_alu_op;
                    offset[i]   <= i_disp_offset;
                    prs1[i]     <= i_disp_prs1;
                    prs2[i]     <= i_disp_prs2;
                    prd[i]      <= i_disp_prd;
                    rob[i]      <= i_disp_rob_tag;
                    rdy1[i]     <= i_disp_prs1_rdy | wake(i_disp_prs1);
                    rdy2[i]     <= i_disp_memwrite ? (i_disp_prs2_rdy | wake(i_disp_prs2)) : 1'b1;
                    age[i]      <= valid & ~kill;
                end else begin
                    if (kill[i]) begin
                        valid[i] <= 1'b0;
                    end
                    rdy1[i] <= rdy1[i] | wake(prs1[i]);
                    rdy2[i] <= rdy2[i] | wake(prs2[i]);
                    age[i]  <= age[i] & ~kill;
                end
            end
        end
    end
endmodule

// File: tb/tb_lsu_issue_queue.sv
// Scoreboard bench for lsu_issue_queue: expected issue order queued at dispatch, popped on each LSU handshake.
// Ordering expectations follow LSU_IQ_LOAD_BYPASS_EN when defined.
module tb_lsu_issue_queue;
    logic        clk = 1'b0;
    logic        reset;
    logic        i_disp_valid, o_disp_ready, i_disp_memwrite;
    logic [3:0]  i_disp_alu_op;
    logic [31:0] i_disp_offset;
    logic [6:0]  i_disp_prs1, i_disp_prs2, i_disp_prd;
    logic        i_disp_prs1_rdy, i_disp_prs2_rdy;
    logic [3:0]  i_disp_rob_tag;
    logic        i_wb0_valid, i_wb1_valid;
    logic [6:0]  i_wb0_prd, i_wb1_prd;
    logic        o_iss_valid, i_lsu_ready, o_iss_memwrite;
    logic [3:0]  o_iss_alu_op;
    logic [31:0] o_iss_offset;
    logic [6:0]  o_iss_prs1, o_iss_prs2, o_iss_prd;
    logic [3:0]  o_iss_rob_tag;
    logic        branch_mispredict;
    logic [3:0]  branch_rob_tag;
    logic [3:0]  o_count;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;

    lsu_issue_queue dut (
        .clk(clk), .reset(reset),
        .i_disp_valid(i_disp_valid), .o_disp_ready(o_disp_ready),
        .i_disp_memwrite(i_disp_memwrite), .i_disp_alu_op(i_disp_alu_op),
        .i_disp_offset(i_disp_offset), .i_disp_prs1(i_disp_prs1), .i_disp_prs2(i_disp_prs2),
        .i_disp_prs1_rdy(i_disp_prs1_rdy), .i_disp_prs2_rdy(i_disp_prs2_rdy),
        .i_disp_prd(i_disp_prd), .i_disp_rob_tag(i_disp_rob_tag),
        .i_wb0_valid(i_wb0_valid), .i_wb0_prd(i_wb0_prd),
        .i_wb1_valid(i_wb1_valid), .i_wb1_prd(i_wb1_prd),
        .o_iss_valid(o_iss_valid), .i_lsu_ready(i_lsu_ready),
        .o_iss_memwrite(o_iss_memwrite), .o_iss_alu_op(o_iss_alu_op),
        .o_iss_offset(o_iss_offset), .o_iss_prs1(o_iss_prs1), .o_iss_prs2(o_iss_prs2),
        .o_iss_prd(o_iss_prd), .o_iss_rob_tag(o_iss_rob_tag),
        .branch_mispredict(branch_mispredict), .branch_rob_tag(branch_rob_tag),
        .o_count(o_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pk(input logic mw, input logic [3:0] rob, input logic [6:0] prd);
        return {20'd0, mw, rob, prd};
    endfunction

    function automatic logic [6:0] prd_of(input logic [3:0] rob);
        return {3'd0, rob} + 7'd32;
    endfunction

    // Scoreboard: every handshake must match the next expected op
    always @(negedge clk) begin
        if (!reset && o_iss_valid && i_lsu_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_issue", pk(o_iss_memwrite, o_iss_rob_tag, o_iss_prd), 32'hFFFF_FFFF);
            end else begin
                mon_exp = exp_q.pop_front();
                check("issue_order", pk(o_iss_memwrite, o_iss_rob_tag, o_iss_prd), mon_exp);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_disp(input logic mw, input logic [6:0] p1, input logic r1,
                            input logic [6:0] p2, input logic r2, input logic [3:0] rob);
        i_disp_valid    = 1'b1;
        i_disp_memwrite = mw;
        i_disp_alu_op   = {1'b0, mw ? 3'd2 : 3'd4};
        i_disp_offset   = {28'd0, rob} << 2;
        i_disp_prs1     = p1;
        i_disp_prs1_rdy = r1;
        i_disp_prs2     = p2;
        i_disp_prs2_rdy = r2;
        i_disp_prd      = prd_of(rob);
        i_disp_rob_tag  = rob;
    endtask

    task automatic disp(input logic mw, input logic [6:0] p1, input logic r1,
                        input logic [6:0] p2, input logic r2, input logic [3:0] rob);
        set_disp(mw, p1, r1, p2, r2, rob);
        tick();
        i_disp_valid = 1'b0;
    endtask

    task automatic wait_empty(input int budget);
        for (int k = 0; k < budget; k++) begin
            if (o_count == 4'd0 && exp_q.size() == 0) break;
            tick();
        end
        check("drain_count", {28'd0, o_count}, 32'd0);
        check("drain_sb", exp_q.size(), 32'd0);
    endtask

    initial begin
        reset = 1'b1; i_disp_valid = 1'b0; i_disp_memwrite = 1'b0; i_disp_alu_op = 4'd0;
        i_disp_offset = 32'd0; i_disp_prs1 = 7'd0; i_disp_prs2 = 7'd0; i_disp_prd = 7'd0;
        i_disp_prs1_rdy = 1'b0; i_disp_prs2_rdy = 1'b0; i_disp_rob_tag = 4'd0;
        i_wb0_valid = 1'b0; i_wb0_prd = 7'd0; i_wb1_valid = 1'b0; i_wb1_prd = 7'd0;
        i_lsu_ready = 1'b0; branch_mispredict = 1'b0; branch_rob_tag = 4'd0;
        tick(); tick();
        reset = 1'b0;
        tick();
        check("rst_count", {28'd0, o_count}, 32'd0);
        check("rst_disp_ready", {31'd0, o_disp_ready}, 32'd1);
        check("rst_iss_valid", {31'd0, o_iss_valid}, 32'd0);
        check("rst_iss_rob", {28'd0, o_iss_rob_tag}, 32'd0);
        check("rst_iss_offset", o_iss_offset, 32'd0);

        // Single ready load: eligible the cycle after dispatch
        i_lsu_ready = 1'b1;
        exp_q.push_back(pk(1'b0, 4'd3, prd_of(4'd3)));
        disp(1'b0, 7'd1, 1'b1, 7'd0, 1'b0, 4'd3);
        check("t1_iss_valid", {31'd0, o_iss_valid}, 32'd1);
        check("t1_iss_rob", {28'd0, o_iss_rob_tag}, 32'd3);
        wait_empty(10);

        // Older not-ready load A, younger ready load B
        i_lsu_ready = 1'b0;
        disp(1'b0, 7'd10, 1'b0, 7'd0, 1'b0, 4'd1);
        disp(1'b0, 7'd1, 1'b1, 7'd0, 1'b0, 4'd2);
`ifdef LSU_IQ_LOAD_BYPASS_EN
        exp_q.push_back(pk(1'b0, 4'd2, prd_of(4'd2)));
        i_lsu_ready = 1'b1;
        tick(); tick(); tick();
        check("t2_count", {28'd0, o_count}, 32'd1);
        exp_q.push_back(pk(1'b0, 4'd1, prd_of(4'd1)));
`else
        i_lsu_ready = 1'b1;
        tick(); tick(); tick();
        check("t2_count", {28'd0, o_count}, 32'd2);
        check("t2_iss_valid", {31'd0, o_iss_valid}, 32'd0);
        exp_q.push_back(pk(1'b0, 4'd1, prd_of(4'd1)));
        exp_q.push_back(pk(1'b0, 4'd2, prd_of(4'd2)));
`endif
        i_wb0_valid = 1'b1; i_wb0_prd = 7'd10;
        tick();
        i_wb0_valid = 1'b0;
        wait_empty(10);

        // Store with pending data blocks a younger ready load
        disp(1'b1, 7'd1, 1'b1, 7'd20, 1'b0, 4'd4);
        disp(1'b0, 7'd1, 1'b1, 7'd0, 1'b0, 4'd5);
        tick(); tick();
        check("t3_blocked", {31'd0, o_iss_valid}, 32'd0);
        check("t3_count", {28'd0, o_count}, 32'd2);
        exp_q.push_back(pk(1'b1, 4'd4, prd_of(4'd4)));
        exp_q.push_back(pk(1'b0, 4'd5, prd_of(4'd5)));
        i_wb1_valid = 1'b1; i_wb1_prd = 7'd20;
        tick();
        i_wb1_valid = 1'b0;
        check("t3_wake_valid", {31'd0, o_iss_valid}, 32'd1);
        check("t3_wake_rob", {28'd0, o_iss_rob_tag}, 32'd4);
        wait_empty(10);

        // Fill, refuse dispatch when full, then backpressure and drain one per cycle
        i_lsu_ready = 1'b0;
        for (int k = 0; k < 8; k++) disp(1'b0, 7'(40 + k), 1'b0, 7'd0, 1'b0, 4'(k));
        check("full_count", {28'd0, o_count}, 32'd8);
        check("full_ready", {31'd0, o_disp_ready}, 32'd0);
        disp(1'b0, 7'd1, 1'b1, 7'd0, 1'b0, 4'd9);
        check("full_refuse", {28'd0, o_count}, 32'd8);
        for (int p = 0; p < 4; p++) begin
            i_wb0_valid = 1'b1; i_wb0_prd = 7'(40 + 2 * p);
            i_wb1_valid = 1'b1; i_wb1_prd = 7'(41 + 2 * p);
            tick();
        end
        i_wb0_valid = 1'b0; i_wb1_valid = 1'b0;
        for (int k = 0; k < 8; k++) exp_q.push_back(pk(1'b0, 4'(k), prd_of(4'(k))));
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_valid", {31'd0, o_iss_valid}, 32'd1);
            check("bp_count", {28'd0, o_count}, 32'd8);
            check("bp_rob", {28'd0, o_iss_rob_tag}, 32'd0);
        end
        i_lsu_ready = 1'b1;
        set_disp(1'b0, 7'd1, 1'b1, 7'd0, 1'b0, 4'd9);
        tick();
        i_disp_valid = 1'b0;
        check("full_issue_no_slot", {28'd0, o_count}, 32'd7);
        for (int k = 2; k <= 8; k++) begin
            tick();
            check("drain_step", {28'd0, o_count}, 32'(8 - k));
        end
        check("drain_sb_full", exp_q.size(), 32'd0);

        // Flush younger than branch 5 with a dropped same-cycle dispatch
        i_lsu_ready = 1'b0;
        disp(1'b0, 7'd1, 1'b1, 7'd0, 1'b0, 4'd2);
        disp(1'b0, 7'd1, 1'b1, 7'd0, 1'b0, 4'd5);
        disp(1'b0, 7'd1, 1'b1, 7'd0, 1'b0, 4'd6);
        disp(1'b0, 7'd1, 1'b1, 7'd0, 1'b0, 4'd7);
        branch_mispredict = 1'b1; branch_rob_tag = 4'd5;
        disp(1'b0, 7'd1, 1'b1, 7'd0, 1'b0, 4'd8);
        branch_mispredict = 1'b0;
        check("flush_count", {28'd0, o_count}, 32'd2);
        exp_q.push_back(pk(1'b0, 4'd2, prd_of(4'd2)));
        exp_q.push_back(pk(1'b0, 4'd5, prd_of(4'd5)));
        i_lsu_ready = 1'b1;
        wait_empty(10);

        // Flush with wrapping tags around branch 14
        i_lsu_ready = 1'b0;
        disp(1'b0, 7'd1, 1'b1, 7'd0, 1'b0, 4'd13);
        disp(1'b0, 7'd1, 1'b1, 7'd0, 1'b0, 4'd14);
        disp(1'b0, 7'd1, 1'b1, 7'd0, 1'b0, 4'd15);
        disp(1'b0, 7'd1, 1'b1, 7'd0, 1'b0, 4'd0);
        disp(1'b0, 7'd1, 1'b1, 7'd0, 1'b0, 4'd1);
        branch_mispredict = 1'b1; branch_rob_tag = 4'd14;
        disp(1'b0, 7'd1, 1'b1, 7'd0, 1'b0, 4'd2);
        branch_mispredict = 1'b0;
        check("wrap_flush_count", {28'd0, o_count}, 32'd2);
        exp_q.push_back(pk(1'b0, 4'd13, prd_of(4'd13)));
        exp_q.push_back(pk(1'b0, 4'd14, prd_of(4'd14)));
        i_lsu_ready = 1'b1;
        wait_empty(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsu_issue_queue.md
# lsu_issue_queue

Out-of-order issue queue and scheduler in front of the load/store unit. Holds up to DEPTH dispatched memory micro-ops and tracks source-operand readiness through writeback tag broadcasts. Each cycle it selects the oldest eligible entry, enforcing conservative memory ordering, and presents it to the LSU under a valid/ready handshake. Entries younger than a mispredicted branch are squashed using the same ROB-age rule as the rest of the backend.

## Interface
Parameters:
- DEPTH, 8, number of queue entries (power of two, 2..16)
- ROB_WIDTH, 4, ROB tag width
- PREG_WIDTH, 7, physical register tag width
- DATA_WIDTH, 32, offset/immediate width

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- i_disp_valid  in  1  dispatch request
- o_disp_ready  out  1  queue can accept a dispatch this cycle
- i_disp_memwrite  in  1  1 = store, 0 = load
- i_disp_alu_op  in  4  funct3 in [2:0], passed through to the LSU
- i_disp_offset  in  DATA_WIDTH  address immediate
- i_disp_prs1 / i_disp_prs2  in  PREG_WIDTH  base / store-data source tags
- i_disp_prs1_rdy / i_disp_prs2_rdy  in  1  source already available (prs2_rdy is ignored for loads; treated as 1)
- i_disp_prd  in  PREG_WIDTH  destination tag
- i_disp_rob_tag  in  ROB_WIDTH  ROB tag
- i_wb0_valid, i_wb0_prd / i_wb1_valid, i_wb1_prd  in  1, PREG_WIDTH  wakeup broadcasts
- o_iss_valid  out  1  selected entry presented to the LSU
- i_lsu_ready  in  1  LSU accepts the op (LSU o_ready)
- o_iss_memwrite, o_iss_alu_op, o_iss_offset, o_iss_prs1, o_iss_prs2, o_iss_prd, o_iss_rob_tag  out  as dispatch  fields of the selected entry
- branch_mispredict  in  1  flush request
- branch_rob_tag  in  ROB_WIDTH  mispredicted branch tag
- o_count  out  $clog2(DEPTH)+1  number of valid entries

## Operation
- Entry state: valid, issued-pending (none; entries free on issue), the dispatch fields, rdy1, rdy2, and an age-matrix row.
- Dispatch: accepted when i_disp_valid && o_disp_ready. The op is written to the lowest-index free entry. Its age row marks every currently valid entry as older.
- Wakeup: any valid entry whose prsN equals a valid wb tag sets rdyN. A dispatch in the same cycle as a matching broadcast captures the wakeup: rdyN = i_disp_prsN_rdy OR match.
- Eligibility:
  - Load: rdy1, and no older valid store exists.
  - Store: rdy1 && rdy2, and no older valid entry of any kind exists.
  - Loads are never reordered around stores.
- Select: the oldest eligible entry, i.e. one with no older eligible entry in the age matrix. o_iss_valid = 1 if any entry is eligible. All o_iss_* fields are combinational from that entry.
- Issue: on o_iss_valid && i_lsu_ready at the clock edge, the selected entry is freed. Its bit is cleared from every age row.
- Flush: when branch_mispredict is high, every entry with d = rob_tag − branch_rob_tag (mod 2^ROB_WIDTH), d ≠ 0 and d < 2^(ROB_WIDTH−1), is invalidated at the edge. A same-cycle dispatch of a younger tag is dropped. The branch itself and older entries survive.
- Flush does not gate o_iss_valid. The LSU discards younger ops itself. An entry issued in a flush cycle is freed regardless.

## Timing
- Reset:
  - All entries invalid, age matrix cleared.
  - o_disp_ready = 1, o_iss_valid = 0, o_count = 0.
  - o_iss_* fields are 0.
- Latency:
  - Dispatch with ready operands → eligible the next cycle (minimum 1-cycle dispatch-to-issue).
  - Wakeup at cycle N → eligible at N+1.
- Backpressure: while i_lsu_ready = 0, the selection may change (an older entry may become eligible). Nothing is freed.
- Full: o_disp_ready = (o_count < DEPTH), computed from registered state only. With a full queue, a same-cycle issue does not open a slot; dispatch is refused that cycle.
- o_count is updated at the edge: +dispatch accepted (and not flushed), −issued, −flushed. The issue and flush of the same entry count once.
- Reset asserted mid-operation overrides dispatch, issue and flush in that cycle.

## Configuration
- LSU_IQ_LOAD_BYPASS_EN defined: eligibility is as described above, so a ready load may issue ahead of older not-ready loads.
- Not defined: a load additionally requires that no older valid entry of any kind exists. This gives strict program-order issue of all memory ops, with the oldest entry as the only candidate.

## Test plan
- Reset, then dispatch load (prs1_rdy=1, rob 3) → o_iss_valid=1 the next cycle with rob_tag 3. With i_lsu_ready=1, the queue empties and o_count returns to 0.
- Load A (rob 1, prs1=10 not ready), then load B (rob 2, ready):
  - With LSU_IQ_LOAD_BYPASS_EN, B issues first.
  - Without it, nothing issues until wb0 prd=10; then A issues, then B.
- Store S (rob 4, data prs2=20 not ready), then ready load L (rob 5) → no issue. Broadcast wb1 prd=20 → S issues, then L the next cycle.
- Fill 8 entries, all not ready → o_disp_ready=0 and o_count=8. A dispatch attempt is ignored, and o_count stays 8.
- Entries rob 2, 5, 6, 7 with branch_mispredict, branch_rob_tag=5 → only rob 2 and 5 remain (o_count=2). A same-cycle dispatch of rob 8 is dropped. Repeat with tags wrapping (branch 14, entries 15, 0, 1 flushed, 13 kept).
- i_lsu_ready=0 for 5 cycles with an eligible entry → o_iss_valid holds and the entry stays. Raising ready frees exactly one entry per cycle.
